// File: rtl/clock_reset_sequencer.sv
// Clock/reset sequencer: synchronizes one async reset, then releases N_CH channel
// resets in a staggered order and runs a live-programmable divider per channel.
module clock_reset_sequencer #(
  parameter int N_CH      = 4,
  parameter int RESET_CNT = 100,
  parameter int STAGGER   = 8,
  parameter int DIV_WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      sw_reset,
  input  logic [N_CH*DIV_WIDTH-1:0] div,
  output logic [N_CH-1:0]           ch_reset,
  output logic [N_CH-1:0]           ch_tick,
  output logic [N_CH-1:0]           ch_clk,
  output logic                      done
);

  localparam int HOLD_W = $clog2(RESET_CNT + 1);
  localparam int STAG_W = $clog2(STAGGER + 1);
  localparam int IDX_W  = $clog2(N_CH + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CNT - 1);
  localparam logic [STAG_W-1:0] STAG_LAST = STAG_W'(STAGGER - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_CH - 1);

  typedef enum logic [1:0] {
    HOLD,
    RELEASE,
    RUN
  } state_t;

  state_t                 state;
  logic [HOLD_W-1:0]      hold_cnt;
  logic [STAG_W-1:0]      stag_cnt;
  logic [IDX_W-1:0]       ch_idx;
  logic [DIV_WIDTH-1:0]   div_cnt [N_CH];

  logic [1:0]             rst_sync;
  logic                   rst_i;

  // Assert immediately with reset, release two edges after reset drops (edge E0).
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rst_sync <= 2'b11;
    end else begin
      rst_sync <= {rst_sync[0], 1'b0};
    end
  end

  assign rst_i = rst_sync[1];

  // Release sequencer: hold all channels, then free them one per STAGGER cycles.
  always_ff @(posedge clock or posedge rst_i) begin
    if (rst_i) begin
      state    <= HOLD;
      hold_cnt <= '0;
      stag_cnt <= '0;
      ch_idx   <= '0;
      ch_reset <= '1;
      done     <= 1'b0;
    end else if (sw_reset) begin
      state    <= HOLD;
      hold_cnt <= '0;
      stag_cnt <= '0;
      ch_idx   <= '0;
      ch_reset <= '1;
      done     <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt    <= '0;
            ch_reset[0] <= 1'b0;
            if (N_CH == 1) begin
              state <= RUN;
              done  <= 1'b1;
            end else begin
              state  <= RELEASE;
              ch_idx <= IDX_W'(1);
            end
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        RELEASE: begin
          if (stag_cnt == STAG_LAST) begin
            stag_cnt <= '0;
            for (int k = 0; k < N_CH; k++) begin
              if (ch_idx == IDX_W'(k)) ch_reset[k] <= 1'b0;
            end
            if (ch_idx == IDX_LAST) begin
              state <= RUN;
              done  <= 1'b1;
            end else begin
              ch_idx <= ch_idx + IDX_W'(1);
            end
          end else begin
            stag_cnt <= stag_cnt + STAG_W'(1);
          end
        end

        RUN: begin
        end

        default: state <= HOLD;
      endcase
    end
  end

  // Per-channel dividers. The divisor is read live and compared with >=, so
  // lowering it mid-count ticks on the next edge instead of wrapping the counter.
  // NOTE: div_cnt is a handful of flops rather than a RAM, so it takes the reset too.
  always_ff @(posedge clock or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < N_CH; k++) div_cnt[k] <= '0;
      ch_tick <= '0;
      ch_clk  <= '0;
    end else if (sw_reset) begin
      for (int k = 0; k < N_CH; k++) div_cnt[k] <= '0;
      ch_tick <= '0;
      ch_clk  <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (ch_reset[k]) begin
          div_cnt[k] <= '0;
          ch_tick[k] <= 1'b0;
          ch_clk[k]  <= 1'b0;
        end else if (div_cnt[k] >= div[k*DIV_WIDTH +: DIV_WIDTH]) begin
          div_cnt[k] <= '0;
          ch_tick[k] <= 1'b1;
          ch_clk[k]  <= ~ch_clk[k];
        end else begin
          div_cnt[k] <= div_cnt[k] + DIV_WIDTH'(1);
          ch_tick[k] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/clock_reset_sequencer.md
# clock_reset_sequencer

Synthesizable, parametrised clock/reset sequencer for the UART responder designs and their benches. It turns one board clock and one asynchronous reset into N_CH staggered channel resets, with per-channel clock-enable ticks and divided clocks. It sits at the top of a design or testbench and feeds every downstream block (UART core, responder logic, BFMs). It adds four things a fixed-count generator cannot do: runtime division, staggered release, software re-sequencing and a done flag.

## Interface
- N_CH, 4, number of output channels (>=1)
- RESET_CNT, 100, cycles all channels stay in reset after internal reset release (>=1)
- STAGGER, 8, cycles between successive channel releases (>=1)
- DIV_WIDTH, 8, width of each channel divisor
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- sw_reset  in  1  synchronous request to re-run the release sequence; sampled on rising edge
- div  in  N_CH*DIV_WIDTH  channel k divisor d_k = div[k*DIV_WIDTH +: DIV_WIDTH]; read live, not latched
- ch_reset  out  N_CH  per-channel active-high reset, registered
- ch_tick  out  N_CH  one-cycle clock-enable pulse, once every d_k+1 cycles
- ch_clk  out  N_CH  divided clock; toggles on every ch_tick, so its period is 2*(d_k+1) cycles
- done  out  1  high once all channels are released

## Operation
- Reset synchronizer: a 2-flop synchronizer produces rst_i, which asserts asynchronously with reset and deasserts on the 2nd rising edge with reset low (edge E0). All other flops reset on rst_i.
- Reset values: ch_reset = all 1, ch_tick = 0, ch_clk = 0, done = 0, state = HOLD, all counters 0.
- FSM states:
  - HOLD: hold_cnt increments each cycle. On the edge where hold_cnt == RESET_CNT-1: ch_reset[0] <= 0, hold_cnt <= 0. Next state is RELEASE, or RUN with done <= 1 if N_CH == 1.
  - RELEASE: stag_cnt increments each cycle. On the edge where stag_cnt == STAGGER-1: release the next channel index and clear stag_cnt. Releasing channel N_CH-1 also sets done <= 1 and moves to RUN.
  - RUN: idle; all channels free-run.
- Channel divider k: div_cnt_k is held at 0 while ch_reset[k] = 1. While ch_reset[k] = 0, each edge does one of:
  - if div_cnt_k >= d_k: ch_tick[k] <= 1, div_cnt_k <= 0, ch_clk[k] <= ~ch_clk[k];
  - otherwise: div_cnt_k++, ch_tick[k] <= 0.
- Comparison is >=, so lowering d_k mid-count causes a tick on the next edge, never a counter overrun. d_k = 0 gives ch_tick[k] constantly high and ch_clk[k] = clock/2.
- sw_reset = 1 in any state: on the next edge, all outputs and counters return to their reset values and state = HOLD. While sw_reset stays high, the block stays in HOLD with hold_cnt = 0.
- Async reset mid-sequence: all outputs go to their reset values immediately, with no dependence on clock.
- Counter widths: hold_cnt is $clog2(RESET_CNT+1), stag_cnt is $clog2(STAGGER+1), channel index is $clog2(N_CH+1), div_cnt_k is DIV_WIDTH.

## Timing
- ch_reset[k] falls at edge E0 + RESET_CNT + k*STAGGER.
- done rises at the same edge as ch_reset[N_CH-1] falls.
- After sw_reset, latency is measured from E_s, the last edge sampling sw_reset = 1: ch_reset[k] falls at E_s + RESET_CNT + k*STAGGER.
- Channel k is released at edge E_k. Its first ch_tick[k] rises at E_k + 1 + d_k and lasts one cycle. Later ticks follow every d_k+1 edges.
- ch_clk[k] changes only on edges where ch_tick[k] rises.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- Power-on (defaults, div = 0): reset high 5 cycles, then low -> ch_reset falls at E0+100, +108, +116, +124. done rises at E0+124. No ch_tick before a channel's release.
- Divider ratios with div = {8'd0, 8'd1, 8'd4, 8'd9} (ch3..ch0) -> ch_tick period is 10, 5, 2 and 1 cycles on ch0..ch3. ch_clk period is 20, 10, 4 and 2 cycles.
- Live divisor change: ch0 at d = 9 with div_cnt = 7, div set to 3 -> tick on the next edge, then every 4 cycles.
- sw_reset one-cycle pulse in RUN -> all ch_reset = 1 and done = 0 on the next edge. ch_reset[0] falls 100 edges after the pulse edge. Holding sw_reset for 50 cycles delays the release by 50 cycles.
- Async reset asserted during RELEASE (after ch0 and ch1 are released) -> ch_reset = 4'hF, ch_tick = 0, ch_clk = 0 and done = 0 without any clock edge. The full sequence repeats after release.
- N_CH = 1, RESET_CNT = 1 -> ch_reset[0] and done change at E0+1. The RELEASE state is never entered.
